// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Arbitrates the single data-memory port between the execute stage and the
// debug/loader port. Each access is latched at grant and held until the memory
// signals ready. Data comes back with a one-cycle done pulse to the owner.
// Two guards protect the port:
//   - after STARVE_LIMIT back-to-back execute wins over a waiting debug
//     request, the next grant goes to debug;
//   - an access with no ready for TIMEOUT cycles is aborted, returns 8'hFF
//     and sets the sticky acc_err flag.
//
// Ports
//   clk, reset_                 clock, synchronous active-low reset
//   ex_mem_*                    execute request in; read data, done and stall out
//   dbg_*                       debug request in; read data and done out
//   d_mem_*                     data SRAM port (registered strobes/addr/data)
//   acc_err                     sticky timeout flag, cleared only by reset
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,   // 1..15
    parameter int TIMEOUT      = 16   // 2..255
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic [11:0] ex_mem_addr,
    input  logic [7:0]  ex_mem_wdata,
    input  logic        ex_mem_en,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wr,
    output logic [7:0]  ex_mem_rdata,
    output logic        ex_done,
    output logic        ex_stall,
    input  logic        dbg_req,
    input  logic        dbg_wr,
    input  logic [11:0] dbg_addr,
    input  logic [7:0]  dbg_wdata,
    output logic [7:0]  dbg_rdata,
    output logic        dbg_done,
    output logic [11:0] d_mem_addr,
    output logic [7:0]  d_mem_wdata,
    input  logic [7:0]  d_mem_rdata,
    output logic        d_mem_en,
    output logic        d_mem_rd,
    output logic        d_mem_wr,
    input  logic        d_mem_ready,
    output logic        acc_err
);

    typedef enum logic [1:0] {IDLE, EX_ACC, DBG_ACC} state_t;

    state_t     state;
    logic [3:0] starve_cnt;
    logic [7:0] to_cnt;
    logic       ex_req;
    logic       done_now;
    logic       ex_wins;

    assign ex_req   = ex_mem_en & (ex_mem_rd | ex_mem_wr);
    assign ex_stall = ex_req & ~ex_done;
    // A done cycle is never a grant cycle, so a request still held across
    // its own done pulse cannot be served twice.
    assign done_now = ex_done | dbg_done;
    assign ex_wins  = ex_req & (~dbg_req | (starve_cnt < 4'(STARVE_LIMIT)));

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            to_cnt       <= '0;
            ex_mem_rdata <= '0;
            ex_done      <= 1'b0;
            dbg_rdata    <= '0;
            dbg_done     <= 1'b0;
            d_mem_addr   <= '0;
            d_mem_wdata  <= '0;
            d_mem_en     <= 1'b0;
            d_mem_rd     <= 1'b0;
            d_mem_wr     <= 1'b0;
            acc_err      <= 1'b0;
        end else begin
            ex_done  <= 1'b0;
            dbg_done <= 1'b0;
            if (!dbg_req)
                starve_cnt <= '0;

            case (state)
                IDLE: begin
                    if (!done_now) begin
                        if (ex_wins) begin
                            state       <= EX_ACC;
                            to_cnt      <= '0;
                            d_mem_addr  <= ex_mem_addr;
                            d_mem_wdata <= ex_mem_wdata;
                            d_mem_en    <= 1'b1;
                            // rd+wr together is treated as a write
                            d_mem_wr    <= ex_mem_wr;
                            d_mem_rd    <= ~ex_mem_wr;
                            if (dbg_req)
                                starve_cnt <= starve_cnt + 4'd1;
                        end else if (dbg_req) begin
                            state       <= DBG_ACC;
                            to_cnt      <= '0;
                            starve_cnt  <= '0;
                            d_mem_addr  <= dbg_addr;
                            d_mem_wdata <= dbg_wdata;
                            d_mem_en    <= 1'b1;
                            d_mem_wr    <= dbg_wr;
                            d_mem_rd    <= ~dbg_wr;
                        end
                    end
                end

                EX_ACC, DBG_ACC: begin
                    // Ready in the final timeout cycle still completes normally.
                    if (d_mem_ready || (to_cnt == 8'(TIMEOUT - 1))) begin
                        state    <= IDLE;
                        d_mem_en <= 1'b0;
                        d_mem_rd <= 1'b0;
                        d_mem_wr <= 1'b0;
                        if (!d_mem_ready)
                            acc_err <= 1'b1;
                        if (state == EX_ACC) begin
                            ex_done      <= 1'b1;
                            ex_mem_rdata <= !d_mem_ready ? 8'hFF :
                                            d_mem_rd     ? d_mem_rdata : 8'h00;
                        end else begin
                            dbg_done  <= 1'b1;
                            dbg_rdata <= !d_mem_ready ? 8'hFF :
                                         d_mem_rd     ? d_mem_rdata : 8'h00;
                        end
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_;
    logic [11:0] ex_mem_addr;
    logic [7:0]  ex_mem_wdata;
    logic        ex_mem_en, ex_mem_rd, ex_mem_wr;
    logic [7:0]  ex_mem_rdata;
    logic        ex_done, ex_stall;
    logic        dbg_req, dbg_wr;
    logic [11:0] dbg_addr;
    logic [7:0]  dbg_wdata;
    logic [7:0]  dbg_rdata;
    logic        dbg_done;
    logic [11:0] d_mem_addr;
    logic [7:0]  d_mem_wdata;
    logic [7:0]  d_mem_rdata;
    logic        d_mem_en, d_mem_rd, d_mem_wr;
    logic        d_mem_ready;
    logic        acc_err;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset_(reset_),
        .ex_mem_addr(ex_mem_addr), .ex_mem_wdata(ex_mem_wdata),
        .ex_mem_en(ex_mem_en), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_mem_rdata(ex_mem_rdata), .ex_done(ex_done), .ex_stall(ex_stall),
        .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
        .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
        .d_mem_rdata(d_mem_rdata), .d_mem_en(d_mem_en), .d_mem_rd(d_mem_rd),
        .d_mem_wr(d_mem_wr), .d_mem_ready(d_mem_ready), .acc_err(acc_err)
    );

    always #5 clk = ~clk;

    // Per-cycle vector: inputs driven in the cycle, outputs expected in it.
    // ctl = {d_mem_en, d_mem_rd, d_mem_wr, ex_done, dbg_done, ex_stall}
    typedef struct {
        logic [2:0]  ex_c;   // {en, rd, wr}
        logic [11:0] ex_a;
        logic [7:0]  ex_w;
        logic [1:0]  dbg_c;  // {req, wr}
        logic [11:0] dbg_a;
        logic [7:0]  dbg_w;
        logic        rdy;
        logic [7:0]  mrd;
        logic [5:0]  ctl;
        logic [11:0] xa;     // expected d_mem_addr when d_mem_en
        logic [7:0]  xw;     // expected d_mem_wdata when d_mem_wr
        logic [7:0]  xr;     // expected rdata of the done owner
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_mem_en = 0; ex_mem_rd = 0; ex_mem_wr = 0;
        ex_mem_addr = '0; ex_mem_wdata = '0;
        dbg_req = 0; dbg_wr = 0; dbg_addr = '0; dbg_wdata = '0;
        d_mem_ready = 0; d_mem_rdata = '0;
    endtask

    function automatic vec_t row(logic [2:0] ex_c, logic [11:0] ex_a, logic [7:0] ex_w,
                                 logic [1:0] dbg_c, logic [11:0] dbg_a, logic [7:0] dbg_w,
                                 logic rdy, logic [7:0] mrd, logic [5:0] ctl,
                                 logic [11:0] xa, logic [7:0] xw, logic [7:0] xr);
        vec_t v;
        v.ex_c = ex_c; v.ex_a = ex_a; v.ex_w = ex_w;
        v.dbg_c = dbg_c; v.dbg_a = dbg_a; v.dbg_w = dbg_w;
        v.rdy = rdy; v.mrd = mrd; v.ctl = ctl;
        v.xa = xa; v.xw = xw; v.xr = xr;
        return v;
    endfunction

    vec_t tbl[15];

    initial begin
        int  grants;
        int  last_rise;
        int  rise_cyc;
        int  en_cycles;
        logic prev_en;
        logic overlap;
        logic got;
        logic [9:0] pattern;

        // Exec read A5, ready in 3rd access cycle
        tbl[0]  = row(3'b110, 12'h0A5, 8'h00, 2'b00, 12'h000, 8'h00, 0, 8'h00, 6'b000001, 12'h000, 8'h00, 8'h00);
        tbl[1]  = row(3'b110, 12'h0A5, 8'h00, 2'b00, 12'h000, 8'h00, 0, 8'h00, 6'b110001, 12'h0A5, 8'h00, 8'h00);
        tbl[2]  = row(3'b110, 12'h0A5, 8'h00, 2'b00, 12'h000, 8'h00, 0, 8'h00, 6'b110001, 12'h0A5, 8'h00, 8'h00);
        tbl[3]  = row(3'b110, 12'h0A5, 8'h00, 2'b00, 12'h000, 8'h00, 1, 8'h3C, 6'b110001, 12'h0A5, 8'h00, 8'h00);
        tbl[4]  = row(3'b110, 12'h0A5, 8'h00, 2'b00, 12'h000, 8'h00, 0, 8'h00, 6'b000100, 12'h000, 8'h00, 8'h3C);
        tbl[5]  = row(3'b000, 12'h000, 8'h00, 2'b00, 12'h000, 8'h00, 0, 8'h00, 6'b000000, 12'h000, 8'h00, 8'h00);
        // Debug write 77 -> FFF, zero-wait; write returns 00 despite bus garbage
        tbl[6]  = row(3'b000, 12'h000, 8'h00, 2'b11, 12'hFFF, 8'h77, 0, 8'h00, 6'b000000, 12'h000, 8'h00, 8'h00);
        tbl[7]  = row(3'b000, 12'h000, 8'h00, 2'b11, 12'hFFF, 8'h77, 1, 8'hEE, 6'b101000, 12'hFFF, 8'h77, 8'h00);
        tbl[8]  = row(3'b000, 12'h000, 8'h00, 2'b11, 12'hFFF, 8'h77, 0, 8'h00, 6'b000010, 12'h000, 8'h00, 8'h00);
        // Ready while idle is ignored
        tbl[9]  = row(3'b000, 12'h000, 8'h00, 2'b00, 12'h000, 8'h00, 1, 8'h55, 6'b000000, 12'h000, 8'h00, 8'h00);
        tbl[10] = row(3'b000, 12'h000, 8'h00, 2'b00, 12'h000, 8'h00, 1, 8'h55, 6'b000000, 12'h000, 8'h00, 8'h00);
        // Exec rd+wr together -> write only
        tbl[11] = row(3'b111, 12'h123, 8'h5A, 2'b00, 12'h000, 8'h00, 0, 8'h00, 6'b000001, 12'h000, 8'h00, 8'h00);
        tbl[12] = row(3'b111, 12'h123, 8'h5A, 2'b00, 12'h000, 8'h00, 1, 8'hEE, 6'b101001, 12'h123, 8'h5A, 8'h00);
        tbl[13] = row(3'b111, 12'h123, 8'h5A, 2'b00, 12'h000, 8'h00, 0, 8'h00, 6'b000100, 12'h000, 8'h00, 8'h00);
        tbl[14] = row(3'b000, 12'h000, 8'h00, 2'b00, 12'h000, 8'h00, 0, 8'h00, 6'b000000, 12'h000, 8'h00, 8'h00);

        // ---- reset ----
        idle_inputs();
        reset_ = 0;
        cyc(); cyc();
        #3;
        chk("reset_ctl", 32'({d_mem_en, d_mem_rd, d_mem_wr, ex_done, dbg_done, acc_err}), 32'h0);
        chk("reset_bus", 32'({d_mem_addr, d_mem_wdata}), 32'h0);
        chk("reset_rdata", 32'({ex_mem_rdata, dbg_rdata}), 32'h0);
        cyc();
        reset_ = 1;

        // ---- table vectors ----
        for (int i = 0; i < 15; i++) begin
            cyc();
            {ex_mem_en, ex_mem_rd, ex_mem_wr} = tbl[i].ex_c;
            ex_mem_addr = tbl[i].ex_a; ex_mem_wdata = tbl[i].ex_w;
            {dbg_req, dbg_wr} = tbl[i].dbg_c;
            dbg_addr = tbl[i].dbg_a; dbg_wdata = tbl[i].dbg_w;
            d_mem_ready = tbl[i].rdy; d_mem_rdata = tbl[i].mrd;
            #3;
            chk($sformatf("vec%0d_ctl", i),
                32'({d_mem_en, d_mem_rd, d_mem_wr, ex_done, dbg_done, ex_stall}), 32'(tbl[i].ctl));
            if (tbl[i].ctl[5]) chk($sformatf("vec%0d_addr", i), 32'(d_mem_addr), 32'(tbl[i].xa));
            if (tbl[i].ctl[3]) chk($sformatf("vec%0d_wdata", i), 32'(d_mem_wdata), 32'(tbl[i].xw));
            if (tbl[i].ctl[2]) chk($sformatf("vec%0d_ex_rdata", i), 32'(ex_mem_rdata), 32'(tbl[i].xr));
            if (tbl[i].ctl[1]) chk($sformatf("vec%0d_dbg_rdata", i), 32'(dbg_rdata), 32'(tbl[i].xr));
        end

        // ---- starvation: continuous requests, zero-wait memory ----
        ex_mem_en = 1; ex_mem_rd = 1; ex_mem_addr = 12'h111;
        dbg_req = 1; dbg_wr = 0; dbg_addr = 12'h222;
        d_mem_ready = 1; d_mem_rdata = 8'h42;
        grants = 0; prev_en = 0; overlap = 0; last_rise = 0; pattern = '0;
        for (int c = 0; c < 100 && grants < 10; c++) begin
            cyc(); #3;
            if (ex_done && dbg_done) overlap = 1;
            if (d_mem_en && !prev_en) begin
                pattern[grants] = (d_mem_addr == 12'h222);
                if (grants > 0) chk($sformatf("turnaround%0d", grants), 32'(c - last_rise), 32'd3);
                last_rise = c;
                grants++;
            end
            prev_en = d_mem_en;
        end
        chk("starve_grants", 32'(grants), 32'd10);
        // bit i = 1 for a debug grant: EX,EX,EX,EX,DBG,EX,EX,EX,EX,DBG
        chk("starve_pattern", 32'(pattern), 32'(10'b10000_10000));
        chk("done_overlap", 32'(overlap), 32'd0);
        cyc(); idle_inputs();
        cyc(); cyc(); cyc();

        // ---- timeout: exec read, ready never comes ----
        #3;
        chk("acc_err_before", 32'(acc_err), 32'd0);
        cyc();
        ex_mem_en = 1; ex_mem_rd = 1; ex_mem_addr = 12'h0AA;
        en_cycles = 0; got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            cyc(); #3;
            if (d_mem_en) en_cycles++;
            if (ex_done) got = 1;
        end
        chk("timeout_done_seen", 32'(got), 32'd1);
        chk("timeout_cycles", 32'(en_cycles), 32'd16);
        chk("timeout_rdata", 32'(ex_mem_rdata), 32'hFF);
        chk("timeout_strobes", 32'({d_mem_en, d_mem_rd, d_mem_wr}), 32'd0);
        chk("timeout_err", 32'(acc_err), 32'd1);
        cyc(); idle_inputs();
        cyc(); cyc();
        #3;
        chk("acc_err_sticky", 32'(acc_err), 32'd1);

        // ---- reset mid-debug-access with execute pending ----
        cyc();
        dbg_req = 1; dbg_wr = 0; dbg_addr = 12'h333;
        cyc();
        ex_mem_en = 1; ex_mem_rd = 1; ex_mem_addr = 12'h044;
        #3;
        chk("rst_dbg_inflight", 32'({d_mem_en, d_mem_rd, d_mem_addr}), 32'({2'b11, 12'h333}));
        cyc();
        reset_ = 0;
        cyc();
        reset_ = 1; dbg_req = 0;
        #3;
        chk("rst_ctl", 32'({d_mem_en, d_mem_rd, d_mem_wr, ex_done, dbg_done, acc_err}), 32'd0);
        chk("rst_bus", 32'({d_mem_addr, d_mem_wdata, ex_mem_rdata, dbg_rdata}), 32'd0);
        chk("rst_stall", 32'(ex_stall), 32'd1);
        cyc();
        #3;
        chk("rst_ex_grant", 32'({d_mem_en, d_mem_rd, d_mem_wr, d_mem_addr}), 32'({3'b110, 12'h044}));
        chk("rst_no_dbg_done", 32'(dbg_done), 32'd0);
        d_mem_ready = 1; d_mem_rdata = 8'h99;
        cyc();
        d_mem_ready = 0;
        #3;
        chk("rst_ex_done", 32'({ex_done, ex_mem_rdata}), 32'({1'b1, 8'h99}));
        cyc(); idle_inputs();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
